inst_sram_axi_rd_bridge: RTL and testbench

//   Sits upstream of the IF stage. Converts IF's SRAM-like instruction port (req/addr_ok/data_ok) into AXI4 read-only AR/R channels.
//   - Single-beat, in-order reads with one fixed ID.
//   - Up to MAX_OUTSTANDING accepted requests may await data, so IF can keep pre-IF fetches in flight.

---
 rtl/inst_sram_axi_rd_bridge.sv | 147 ++++++++++++++
 tb/tb_inst_sram_axi_rd_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_axi_rd_bridge.sv
// SRAM-like instruction fetch port to AXI4 read-only (AR/R) bridge, single-beat, in-order.
// Optional 1-entry registered R buffer enabled by defining INST_BRIDGE_RBUF_EN.
module inst_sram_axi_rd_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    // SRAM-like instruction port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // AXI4 read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI4 read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_t;

    ar_state_t        ar_state;
    ar_state_t        ar_state_nxt;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    logic [CNT_W-1:0] out_cnt;
    logic             accept;
    logic             ar_fire;
    logic             r_fire;
    logic             cnt_dec;
    logic             unused_inputs;

    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};

    assign arvalid = (ar_state == AR_SEND);
    assign ar_fire = arvalid & arready;

    // Full is judged on the registered count, so a same-cycle return only unblocks next cycle.
    // Gating with reset keeps addr_ok low while reset is held, even though it is combinational.
    assign accept = ~reset & inst_sram_req & ~inst_sram_wr
                  & ((ar_state == AR_IDLE) | ar_fire)
                  & (out_cnt < CNT_MAX);

    assign inst_sram_addr_ok = accept;

    assign arid    = ARID_VAL;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    always_comb begin
        // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
        ar_state_nxt = ar_state;
        unique case (ar_state)
            AR_IDLE: if (accept) ar_state_nxt = AR_SEND;
            AR_SEND: if (ar_fire && !accept) ar_state_nxt = AR_IDLE;
            default: ar_state_nxt = AR_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
        end else begin
            ar_state <= ar_state_nxt;
            if (accept) begin
                addr_q <= inst_sram_addr;
                size_q <= inst_sram_size;
            end
        end
    end

    // accept never fires at CNT_MAX and cnt_dec never fires at zero, so the counter cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_cnt <= '0;
        end else begin
            unique case ({accept, cnt_dec})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

`ifdef INST_BRIDGE_RBUF_EN
    logic        buf_vld;
    logic [31:0] buf_data;

    assign rready = (out_cnt != '0) & ~buf_vld;
    assign r_fire = rvalid & rready & rlast;

    // IF always consumes data_ok, so the buffer holds each return for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_vld  <= 1'b0;
            buf_data <= '0;
        end else begin
            buf_vld <= r_fire;
            if (r_fire) buf_data <= rdata;
        end
    end

    assign inst_sram_data_ok = buf_vld;
    assign inst_sram_rdata   = buf_data;
    assign cnt_dec           = buf_vld;
`else
    assign rready            = (out_cnt != '0);
    assign r_fire            = rvalid & rready & rlast;
    assign inst_sram_data_ok = r_fire;
    assign inst_sram_rdata   = rdata;
    assign cnt_dec           = r_fire;
`endif

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed bench for inst_sram_axi_rd_bridge; returned data is checked against a scoreboard queue.
// Honors INST_BRIDGE_RBUF_EN for the extra return-cycle latency.
module tb_inst_sram_axi_rd_bridge;

`ifdef INST_BRIDGE_RBUF_EN
    localparam bit RBUF = 1'b1;
`else
    localparam bit RBUF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];

    inst_sram_axi_rd_bridge #(
        .MAX_OUTSTANDING(2),
        .ARID_VAL       (4'd0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_wstrb  (inst_sram_wstrb),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .arid             (arid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arlock           (arlock),
        .arcache          (arcache),
        .arprot           (arprot),
        .arvalid          (arvalid),
        .arready          (arready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .rvalid           (rvalid),
        .rready           (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then retire any data_ok against the scoreboard.
    task automatic settle();
        logic [31:0] exp_data;
        #1;
        if (inst_sram_data_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_data_ok", 32'(inst_sram_data_ok), 32'd0);
            end else begin
                exp_data = exp_q.pop_front();
                chk("rdata_order", inst_sram_rdata, exp_data);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            @(negedge clk);
        end
    endtask

    // Present one R beat and hold it until the bridge takes it (bounded).
    task automatic send_r(input logic [31:0] data, input logic [1:0] resp);
        bit fired;
        fired  = 1'b0;
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        rlast  = 1'b1;
        exp_q.push_back(data);
        for (int i = 0; i < 8; i++) begin
            settle();
            if (rready === 1'b1) begin
                fired = 1'b1;
                chk("data_ok_latency", 32'(inst_sram_data_ok), 32'(!RBUF));
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        chk("r_fire_timeout", 32'(fired), 32'd1);
        rvalid = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        inst_sram_req   = 1'b1;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_wstrb = 4'd0;
        inst_sram_addr  = 32'h1c00_0000;
        inst_sram_wdata = 32'd0;
        arready         = 1'b0;
        rid             = 4'd0;
        rdata           = 32'd0;
        rresp           = 2'b00;
        rlast           = 1'b1;
        rvalid          = 1'b0;

        // Reset state, with req high throughout
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arsize", 32'(arsize), 32'd0);
        chk("const_ar", {arid, arlen, arburst, arlock, arcache, arprot}, {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        @(negedge clk);
        reset         = 1'b0;
        inst_sram_req = 1'b0;

        // 1: single fetch
        idle(1);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0000;
        settle();
        chk("t1_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        settle();
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_araddr", araddr, 32'h1c00_0000);
        chk("t1_arsize", 32'(arsize), 32'd2);
        chk("t1_rready", 32'(rready), 32'd1);
        @(negedge clk);
        settle();
        chk("t1_arvalid_drop", 32'(arvalid), 32'd0);
        @(negedge clk);
        send_r(32'h0280_0c0c, 2'b00);
        idle(1);
        settle();
        chk("t1_rready_idle", 32'(rready), 32'd0);
        @(negedge clk);

        // 2: AR backpressure with req held
        arready        = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0040;
        settle();
        chk("t2_addr_ok0", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_addr = 32'h1c00_0044;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_arvalid_hold", 32'(arvalid), 32'd1);
            chk("t2_araddr_stable", araddr, 32'h1c00_0040);
            chk("t2_addr_ok_blocked", 32'(inst_sram_addr_ok), 32'd0);
            @(negedge clk);
        end
        arready = 1'b1;
        settle();
        chk("t2_addr_ok_on_ready", 32'(inst_sram_addr_ok), 32'd1);
        chk("t2_araddr_ready", araddr, 32'h1c00_0040);
        @(negedge clk);
        inst_sram_req = 1'b0;
        settle();
        chk("t2_arvalid_2nd", 32'(arvalid), 32'd1);
        chk("t2_araddr_2nd", araddr, 32'h1c00_0044);
        @(negedge clk);
        settle();
        chk("t2_arvalid_drop", 32'(arvalid), 32'd0);
        @(negedge clk);
        send_r(32'h1111_0040, 2'b00);
        send_r(32'h1111_0044, 2'b00);
        idle(2);

        // 3: outstanding limit
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0100;
        settle();
        chk("t3_acc0", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_addr = 32'h1c00_0104;
        settle();
        chk("t3_acc1", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_addr = 32'h1c00_0108;
        settle();
        chk("t3_full", 32'(inst_sram_addr_ok), 32'd0);
        chk("t3_araddr1", araddr, 32'h1c00_0104);
        @(negedge clk);
        settle();
        chk("t3_full_idle", 32'(inst_sram_addr_ok), 32'd0);
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'h3333_0100;
        exp_q.push_back(32'h3333_0100);
        settle();
        chk("t3_rready", 32'(rready), 32'd1);
        chk("t3_same_cycle_blocked", 32'(inst_sram_addr_ok), 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        if (RBUF) begin
            settle();
            chk("t3_buf_still_full", 32'(inst_sram_addr_ok), 32'd0);
            @(negedge clk);
        end
        settle();
        chk("t3_unblocked", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        settle();
        chk("t3_araddr3", araddr, 32'h1c00_0108);
        @(negedge clk);
        send_r(32'h3333_0104, 2'b00);
        send_r(32'h3333_0108, 2'b00);
        idle(2);

        // 4: ordering of two outstanding reads
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0200;
        idle(1);
        inst_sram_addr = 32'h1c00_0204;
        idle(1);
        inst_sram_req = 1'b0;
        idle(2);
        send_r(32'hAAAA_0000, 2'b00);
        send_r(32'hBBBB_0000, 2'b00);
        settle();
        chk("t4_rready_drop0", 32'(rready), 32'd0);
        @(negedge clk);
        settle();
        chk("t4_rready_drop1", 32'(rready), 32'd0);
        @(negedge clk);

        // 5: asynchronous reset mid-transaction
        arready        = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0300;
        settle();
        chk("t5_acc", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b1;
        settle();
        chk("t5_arvalid_pre", 32'(arvalid), 32'd1);
        chk("t5_rready_pre", 32'(rready), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_arvalid_rst", 32'(arvalid), 32'd0);
        chk("t5_rready_rst", 32'(rready), 32'd0);
        chk("t5_addr_ok_rst", 32'(inst_sram_addr_ok), 32'd0);
        chk("t5_data_ok_rst", 32'(inst_sram_data_ok), 32'd0);
        chk("t5_araddr_rst", araddr, 32'd0);
        @(negedge clk);
        reset          = 1'b0;
        arready        = 1'b1;
        inst_sram_addr = 32'h1c00_0400;
        settle();
        chk("t5_acc_after", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        settle();
        chk("t5_araddr_after", araddr, 32'h1c00_0400);
        @(negedge clk);
        send_r(32'h5555_0400, 2'b00);
        idle(2);

        // 6: write requests rejected, stray R ignored, SLVERR passed through
        inst_sram_req  = 1'b1;
        inst_sram_wr   = 1'b1;
        inst_sram_addr = 32'h1c00_0500;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t6_wr_rejected", 32'(inst_sram_addr_ok), 32'd0);
            @(negedge clk);
        end
        inst_sram_req = 1'b0;
        inst_sram_wr  = 1'b0;
        rvalid        = 1'b1;
        rdata         = 32'hDEAD_0000;
        settle();
        chk("t6_stray_rready", 32'(rready), 32'd0);
        chk("t6_stray_data_ok", 32'(inst_sram_data_ok), 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        idle(1);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0600;
        settle();
        chk("t6_acc", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        idle(2);
        send_r(32'hDEAD_BEEF, 2'b10);
        idle(3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
